uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h5A, frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CLOCKS, default 1000, maximum idle clocks between bytes inside a frame; legal range 2..65535.
REQ-003 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx_data_i, input, 8, received byte from the UART receiver.
REQ-006 SHALL have port rx_valid_i, input, 1, one-clock strobe; rx_data_i is valid while it is high.
REQ-007 SHALL have port cmd_valid_o, output, 1, decoded command pending.
REQ-008 SHALL have port cmd_opcode_o, output, 8, opcode of the pending command.
REQ-009 SHALL have port cmd_arg_o, output, 16, argument of the pending command, {arg_hi, arg_lo}.
REQ-010 SHALL have port cmd_ready_i, input, 1, consumer accepts the pending command.
REQ-011 SHALL have port err_checksum_o, output, 1, one-clock pulse on a bad checksum.
REQ-012 SHALL have port err_timeout_o, output, 1, one-clock pulse on an inter-byte timeout.
REQ-013 SHALL have port err_overflow_o, output, 1, one-clock pulse when a good frame is dropped.
REQ-014 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL parse 5-byte frames: SYNC_BYTE, opcode, arg_hi, arg_lo, check.
REQ-016 SHALL use states IDLE, OPCODE, ARG_HI, ARG_LO, CHECK, advancing one state per byte accepted (rx_valid_i high).
REQ-017 In IDLE, SHALL go to OPCODE only on byte == SYNC_BYTE; other bytes are discarded with no error.
REQ-018 SHALL latch each byte to its field register in OPCODE, ARG_HI and ARG_LO.
REQ-019 In CHECK, SHALL compare the byte to opcode ^ arg_hi ^ arg_lo, then return to IDLE.
REQ-020 Checksum mismatch SHALL pulse err_checksum_o on the next clock; command outputs unchanged.
REQ-021 Checksum match SHALL load cmd_opcode_o and cmd_arg_o, and set cmd_valid_o on the next clock; latency is 1 clock from the check-byte strobe.
REQ-022 cmd_valid_o SHALL stay high, with outputs stable, until a clock edge where cmd_valid_o and cmd_ready_i are both high; it clears after that edge.
REQ-023 Good frame while a command is pending and cmd_ready_i is low SHALL keep the old command, drop the new one, and pulse err_overflow_o.
REQ-024 Good frame in the same clock as the handshake completes SHALL load the new command with cmd_valid_o remaining high.
REQ-025 SHALL keep a 16-bit inter-byte counter in non-IDLE states, reloaded to 0 on each accepted byte and on entry from IDLE.
REQ-026 Counter reaching TIMEOUT_CLOCKS-1 with no byte SHALL return the state to IDLE and pulse err_timeout_o once.
REQ-027 When rx_valid_i and timeout expiry coincide, the byte SHALL win: accepted, counter reloaded, no timeout.
REQ-028 A SYNC_BYTE value received mid-frame SHALL be treated as data, with no resynchronisation.
REQ-029 Error pulses SHALL be mutually exclusive per clock; the register update logic must make this hold by construction.
REQ-030 busy_o SHALL be a registered state decode, with no combinational path from inputs.

Reset
REQ-031 Reset SHALL force IDLE, counter 0, field registers 0, cmd_valid_o 0, cmd_opcode_o 0, cmd_arg_o 0, all err_* 0, busy_o 0.
REQ-032 Reset asserted mid-frame or with a command pending SHALL discard all partial and pending state with no error pulse.
REQ-033 After reset deassertion, the first accepted byte SHALL be processed normally from IDLE.

Verification
REQ-034 Bytes 5A 12 34 56 70 -> cmd_valid_o=1 one clock after the last byte, cmd_opcode_o=12, cmd_arg_o=3456, no errors.
REQ-035 Bytes 5A 12 34 56 71 -> err_checksum_o single pulse, cmd_valid_o stays 0, busy_o=0 afterwards.
REQ-036 Bytes 5A 01, then 1000 idle clocks -> err_timeout_o pulses once, IDLE; then 5A 02 00 03 01 -> cmd 02/0003.
REQ-037 cmd_ready_i=0, frames 5A 01 00 00 01 and 5A 02 00 00 02 -> err_overflow_o pulse, outputs hold 01/0000; ready=1 -> cleared after one edge.
REQ-038 Bytes FF 00 5A 5A 00 00 5A -> leading bytes ignored, cmd 5A/0000 valid.
REQ-039 Reset after 5A 12 34 -> all outputs 0; then 5A AA 00 01 AB -> cmd AA/0001.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// UART command decoder bus: receive strobe, command handshake, status.
// Drivers use master, the decoder uses slave.
interface uart_cmd_decoder_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        cmd_valid_o;
  logic [7:0]  cmd_opcode_o;
  logic [15:0] cmd_arg_o;
  logic        cmd_ready_i;
  logic        err_checksum_o;
  logic        err_timeout_o;
  logic        err_overflow_o;
  logic        busy_o;

  modport master (
    output rx_data_i, rx_valid_i, cmd_ready_i,
    input  cmd_valid_o, cmd_opcode_o, cmd_arg_o,
    input  err_checksum_o, err_timeout_o, err_overflow_o, busy_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, cmd_ready_i,
    output cmd_valid_o, cmd_opcode_o, cmd_arg_o,
    output err_checksum_o, err_timeout_o, err_overflow_o, busy_o
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Frame parser: SYNC, opcode, arg_hi, arg_lo, xor check.
// Emits one pending command with valid/ready and error pulses.
module uart_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h5A,
  parameter int unsigned TIMEOUT_CLOCKS = 1000
) (
  input logic               clock,
  input logic               reset,
  uart_cmd_decoder_if.slave bus
);

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE, OPCODE, ARG_HI, ARG_LO, CHECK
  } state_e;

  // A single error code register makes the pulses exclusive.
  typedef enum logic [1:0] {
    E_NONE, E_CKSUM, E_TOUT, E_OVFL
  } err_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        cv_q, cv_d;
  logic [7:0]  cop_q, cop_d;
  logic [15:0] carg_q, carg_d;
  err_e        err_q, err_d;
  logic        busy_q, busy_d;

  logic take;
  logic hs;
  logic expire;

  assign take   = bus.rx_valid_i;
  assign hs     = cv_q & bus.cmd_ready_i;
  assign expire = (cnt_q == CntLast);

  // Next-state: frame walk, inter-byte timer, command slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cv_d    = cv_q & ~hs;
    cop_d   = cop_q;
    carg_d  = carg_q;
    err_d   = E_NONE;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (take && bus.rx_data_i == SYNC_BYTE) begin
          state_d = OPCODE;
        end
      end
      default: begin
        if (take) begin
          cnt_d = '0;
          unique case (state_q)
            OPCODE: begin
              op_d    = bus.rx_data_i;
              state_d = ARG_HI;
            end
            ARG_HI: begin
              hi_d    = bus.rx_data_i;
              state_d = ARG_LO;
            end
            ARG_LO: begin
              lo_d    = bus.rx_data_i;
              state_d = CHECK;
            end
            default: begin
              state_d = IDLE;
              if (bus.rx_data_i != (op_q ^ hi_q ^ lo_q)) begin
                err_d = E_CKSUM;
              end else if (cv_q && !bus.cmd_ready_i) begin
                err_d = E_OVFL;
              end else begin
                cv_d   = 1'b1;
                cop_d  = op_q;
                carg_d = {hi_q, lo_q};
              end
            end
          endcase
        end else if (expire) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = E_TOUT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cv_q    <= 1'b0;
      cop_q   <= '0;
      carg_q  <= '0;
      err_q   <= E_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cv_q    <= cv_d;
      cop_q   <= cop_d;
      carg_q  <= carg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.cmd_valid_o    = cv_q;
  assign bus.cmd_opcode_o   = cop_q;
  assign bus.cmd_arg_o      = carg_q;
  assign bus.err_checksum_o = (err_q == E_CKSUM);
  assign bus.err_timeout_o  = (err_q == E_TOUT);
  assign bus.err_overflow_o = (err_q == E_OVFL);
  assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder.
// Frame-level reference model feeds expectation queues.
module tb_uart_cmd_decoder;

  localparam logic [7:0] SYNC = 8'h5A;
  localparam int         TO   = 1000;

  typedef struct packed {
    logic        busy;
    logic        valid;
    logic [7:0]  op;
    logic [15:0] arg;
    logic        ck;
    logic        to;
    logic        ov;
  } snap_t;

  typedef struct {
    int          kind;
    logic [7:0]  op;
    logic [15:0] arg;
  } evt_t;

  localparam int K_CMD = 0;
  localparam int K_CK  = 1;
  localparam int K_TO  = 2;
  localparam int K_OV  = 3;

  logic clock = 1'b0;
  logic reset;

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CLOCKS (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  snap_t snap_q[$];
  evt_t  evt_q[$];

  logic [7:0]  frame[$];
  int          idle;
  logic        m_valid;
  logic [7:0]  m_op;
  logic [15:0] m_arg;

  function automatic snap_t dut_snap();
    snap_t s;
    s.busy  = bus.busy_o;
    s.valid = bus.cmd_valid_o;
    s.op    = bus.cmd_opcode_o;
    s.arg   = bus.cmd_arg_o;
    s.ck    = bus.err_checksum_o;
    s.to    = bus.err_timeout_o;
    s.ov    = bus.err_overflow_o;
    return s;
  endfunction

  function automatic void model_clear();
    frame.delete();
    idle    = 0;
    m_valid = 1'b0;
    m_op    = '0;
    m_arg   = '0;
  endfunction

  function automatic void push_evt(int k, logic [7:0] o, logic [15:0] a);
    evt_t e;
    e.kind = k;
    e.op   = o;
    e.arg  = a;
    evt_q.push_back(e);
  endfunction

  // One clock: apply inputs, predict the edge, wait past it.
  task automatic step(input logic v, input logic [7:0] b,
                      input logic rdy);
    snap_t s;
    int    err;
    logic  hs;
    logic  load;
    bus.rx_valid_i  = v;
    bus.rx_data_i   = b;
    bus.cmd_ready_i = rdy;
    s   = '0;
    err = -1;
    if (reset) begin
      model_clear();
    end else begin
      hs   = m_valid && rdy;
      load = 1'b0;
      if (hs) push_evt(K_CMD, m_op, m_arg);
      if (v) begin
        idle = 0;
        if (frame.size() == 0) begin
          if (b == SYNC) frame.push_back(b);
        end else begin
          frame.push_back(b);
          if (frame.size() == 5) begin
            if ((frame[1] ^ frame[2] ^ frame[3]) != frame[4])
              err = K_CK;
            else if (m_valid && !rdy)
              err = K_OV;
            else
              load = 1'b1;
            if (load) begin
              m_op  = frame[1];
              m_arg = {frame[2], frame[3]};
            end
            frame.delete();
          end
        end
      end else if (frame.size() != 0) begin
        idle++;
        if (idle == TO) begin
          err = K_TO;
          frame.delete();
          idle = 0;
        end
      end
      if (load) m_valid = 1'b1;
      else if (hs) m_valid = 1'b0;
      if (err >= 0) push_evt(err, 8'h00, 16'h0000);
      s.busy  = (frame.size() != 0);
      s.valid = m_valid;
      s.op    = m_op;
      s.arg   = m_arg;
      s.ck    = (err == K_CK);
      s.to    = (err == K_TO);
      s.ov    = (err == K_OV);
    end
    snap_q.push_back(s);
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    step(1'b1, b, rdy);
  endtask

  task automatic idle_n(input int n, input logic rdy);
    repeat (n) step(1'b0, 8'h00, rdy);
  endtask

  // Reset between negedge samples so no expectation straddles it.
  task automatic do_reset();
    snap_t got;
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    got = dut_snap();
    n_vec++;
    if (got != '0) begin
      n_miss++;
      $display("FAIL reset_async got=%h want=0", got);
    end
    model_clear();
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  // Monitor: cycle snapshot plus scoreboard of pulses/handshakes.
  initial begin
    snap_t got, exp;
    evt_t  e;
    forever begin
      @(negedge clock);
      if (snap_q.size() != 0) begin
        got = dut_snap();
        exp = snap_q.pop_front();
        n_vec++;
        if (got != exp) begin
          n_miss++;
          $display("FAIL cycle t=%0t got b%b v%b %h/%h e%b%b%b want b%b v%b %h/%h e%b%b%b",
                   $time, got.busy, got.valid, got.op, got.arg,
                   got.ck, got.to, got.ov,
                   exp.busy, exp.valid, exp.op, exp.arg,
                   exp.ck, exp.to, exp.ov);
        end
      end
      for (int k = K_CK; k <= K_OV; k++) begin
        if ((k == K_CK && bus.err_checksum_o) ||
            (k == K_TO && bus.err_timeout_o) ||
            (k == K_OV && bus.err_overflow_o)) begin
          n_vec++;
          if (evt_q.size() == 0) begin
            n_miss++;
            $display("FAIL pulse t=%0t got kind=%0d want none", $time, k);
          end else begin
            e = evt_q.pop_front();
            if (e.kind != k) begin
              n_miss++;
              $display("FAIL pulse t=%0t got kind=%0d want kind=%0d",
                       $time, k, e.kind);
            end
          end
        end
      end
      if (bus.cmd_valid_o && bus.cmd_ready_i && !reset) begin
        n_vec++;
        if (evt_q.size() == 0) begin
          n_miss++;
          $display("FAIL accept t=%0t got %h/%h want none",
                   $time, bus.cmd_opcode_o, bus.cmd_arg_o);
        end else begin
          e = evt_q.pop_front();
          if (e.kind != K_CMD || e.op != bus.cmd_opcode_o ||
              e.arg != bus.cmd_arg_o) begin
            n_miss++;
            $display("FAIL accept t=%0t got %h/%h want kind=%0d %h/%h",
                     $time, bus.cmd_opcode_o, bus.cmd_arg_o,
                     e.kind, e.op, e.arg);
          end
        end
      end
    end
  end

  task automatic frame5(input logic [7:0] o, input logic [7:0] h,
                        input logic [7:0] l, input logic [7:0] c,
                        input logic rdy);
    send(SYNC, rdy);
    send(o, rdy);
    send(h, rdy);
    send(l, rdy);
    send(c, rdy);
  endtask

  initial begin
    logic [7:0] bytes[5];
    int         r;
    logic       rdy;
    reset           = 1'b1;
    bus.rx_valid_i  = 1'b0;
    bus.rx_data_i   = 8'h00;
    bus.cmd_ready_i = 1'b0;
    model_clear();
    do_reset();

    frame5(8'h12, 8'h34, 8'h56, 8'h70, 1'b0);
    idle_n(3, 1'b0);
    idle_n(2, 1'b1);

    frame5(8'h12, 8'h34, 8'h56, 8'h71, 1'b1);
    idle_n(3, 1'b1);

    send(SYNC, 1'b1);
    send(8'h01, 1'b1);
    idle_n(TO, 1'b1);
    idle_n(2, 1'b1);
    frame5(8'h02, 8'h00, 8'h03, 8'h01, 1'b0);
    idle_n(2, 1'b1);

    frame5(8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
    frame5(8'h02, 8'h00, 8'h00, 8'h02, 1'b0);
    idle_n(2, 1'b0);
    idle_n(2, 1'b1);

    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    frame5(SYNC, 8'h00, 8'h00, SYNC, 1'b0);
    idle_n(2, 1'b1);

    send(SYNC, 1'b0);
    send(8'h07, 1'b0);
    idle_n(TO - 1, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h07, 1'b0);
    idle_n(2, 1'b1);

    send(SYNC, 1'b1);
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    do_reset();
    frame5(8'hAA, 8'h00, 8'h01, 8'hAB, 1'b0);
    idle_n(2, 1'b0);
    frame5(8'h33, 8'h44, 8'h55, 8'h66, 1'b0);
    do_reset();
    idle_n(2, 1'b1);

    repeat (250) begin
      idle_n($urandom_range(0, 3), 1'($urandom_range(0, 3) != 0));
      r = $urandom_range(0, 99);
      bytes[0] = SYNC;
      bytes[1] = 8'($urandom);
      bytes[2] = 8'($urandom);
      bytes[3] = 8'($urandom);
      bytes[4] = bytes[1] ^ bytes[2] ^ bytes[3];
      if (r < 15) bytes[4] ^= 8'(1 << $urandom_range(0, 7));
      if (r >= 15 && r < 20) send(8'($urandom), 1'b1);
      for (int i = 0; i < 5; i++) begin
        rdy = 1'($urandom_range(0, 3) != 0);
        if (i == 2 && r >= 20 && r < 23)
          idle_n(TO - 1 + $urandom_range(0, 1), rdy);
        else if (r >= 50)
          idle_n($urandom_range(0, 2), rdy);
        send(bytes[i], rdy);
      end
    end
    idle_n(4, 1'b1);

    @(negedge clock);
    #1;
    n_vec++;
    if (evt_q.size() != 0) begin
      n_miss++;
      $display("FAIL leftover_events got=%0d want=0", evt_q.size());
    end
    n_vec++;
    if (snap_q.size() != 0) begin
      n_miss++;
      $display("FAIL leftover_cycles got=%0d want=0", snap_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
